// File: rtl/sonar_pkg.sv
`default_nettype none
// ============================================================
// Package : sonar_pkg
// Brief   : shared FSM states, ASCII codes and angle lookup
// Rev     : 1.0
// ============================================================
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_TRIG      = 3'd2,
        ST_WAIT_ECHO = 3'd3,
        ST_MEASURE   = 3'd4,
        ST_TX        = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    localparam logic [7:0] c_ASCII_COMMA = 8'h2C;
    localparam logic [7:0] c_ASCII_HASH  = 8'h23;
    localparam logic [7:0] c_ASCII_ZERO  = 8'h30;
    localparam logic [9:0] c_DIST_SAT    = 10'd999;

    // Servo position -> reported angle (20 + 20*pos degrees) as 3 BCD digits
    function automatic logic [11:0] angle_bcd(input logic [2:0] pos);
        logic [11:0] bcd;
        case (pos)
            3'd0:    bcd = 12'h020;
            3'd1:    bcd = 12'h040;
            3'd2:    bcd = 12'h060;
            3'd3:    bcd = 12'h080;
            3'd4:    bcd = 12'h100;
            3'd5:    bcd = 12'h120;
            3'd6:    bcd = 12'h140;
            default: bcd = 12'h160;
        endcase
        return bcd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sonar_uart_tx.sv
`default_nettype none
// ============================================================
// Module : sonar_uart_tx
// Brief  : 8N1 UART transmitter, LSB first, one-clock done pulse
// Rev    : 1.0
// ============================================================
module sonar_uart_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [15:0] c_BIT_LAST = 16'(CLK_HZ / BAUD - 1);

    logic [9:0]  r_shift;
    logic [15:0] r_baud;
    logic [3:0]  r_bits;
    logic        r_busy;
    logic        r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 10'h3FF;
            r_baud  <= 16'd0;
            r_bits  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_start) begin
                    // frame = stop, data, start; shifted out from bit 0
                    r_shift <= {1'b1, i_data, 1'b0};
                    r_busy  <= 1'b1;
                    r_baud  <= 16'd0;
                    r_bits  <= 4'd0;
                end
            end else if (r_baud == c_BIT_LAST) begin
                r_baud <= 16'd0;
                if (r_bits == 4'd9) begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_shift <= 10'h3FF;
                end else begin
                    r_bits  <= r_bits + 4'd1;
                    r_shift <= {1'b1, r_shift[9:1]};
                end
            end else begin
                r_baud <= r_baud + 16'd1;
            end
        end
    end

    assign o_tx   = r_shift[0];
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/sonar.sv
`default_nettype none
// ============================================================
// Module : sonar
// Brief  : sweeping servo sonar; times echoes, reports "aaa,ddd#" over UART
// Rev    : 1.0
// ============================================================
module sonar
    import sonar_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int BAUD          = 115_200,
    parameter int TRIG_CYCLES   = 500,
    parameter int CYC_PER_CM    = 2941,
    parameter int SETTLE_CYCLES = 50_000,
    parameter int ECHO_TIMEOUT  = 1_500_000,
    parameter int PWM_PERIOD    = 1_000_000,
    parameter int PWM_MIN       = 50_000,
    parameter int PWM_STEP      = 7_143
) (
    input  logic clock,
    input  logic reset,
    input  logic ligar,
    input  logic echo,
    output logic trigger,
    output logic pwm,
    output logic saida_serial,
    output logic fim_posicao,
    output logic db_echo,
    output logic db_trigger,
    output logic db_pwm,
    output logic db_saida_serial_uart
);

    localparam logic [31:0] c_SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] c_TRIG_LAST    = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] c_TIMEOUT      = 32'(ECHO_TIMEOUT);
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(ECHO_TIMEOUT - 1);
    localparam logic [31:0] c_CPC_LAST     = 32'(CYC_PER_CM - 1);
    localparam logic [31:0] c_CPC_HALF     = 32'(CYC_PER_CM / 2);
    localparam logic [31:0] c_PWM_LAST     = 32'(PWM_PERIOD - 1);
    localparam logic [31:0] c_PWM_MIN      = 32'(PWM_MIN);
    localparam logic [31:0] c_PWM_STEP     = 32'(PWM_STEP);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_echo_s1;
    logic        r_echo_s2;
    logic        r_echo_d;
    logic [31:0] r_cnt;
    logic [31:0] r_sub;
    logic [31:0] r_cm;
    logic [9:0]  r_dist;
    logic [2:0]  r_pos;
    logic        r_dir_up;
    logic [2:0]  r_char_idx;
    logic        r_tx_go;
    logic [31:0] r_pwm_cnt;
    logic [31:0] r_pwm_width;

    logic        w_echo_rise;
    logic        w_settle_end;
    logic        w_trig_end;
    logic        w_wait_timeout;
    logic        w_meas_timeout;
    logic [31:0] w_cm_round;
    logic [9:0]  w_dist_meas;
    logic [3:0]  w_dist_h;
    logic [3:0]  w_dist_t;
    logic [3:0]  w_dist_u;
    logic [11:0] w_angle;
    logic [7:0]  w_char;
    logic        w_uart_start;
    logic        w_uart_busy;
    logic        w_uart_done;
    logic        w_uart_tx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_echo_s1 <= 1'b0;
            r_echo_s2 <= 1'b0;
            r_echo_d  <= 1'b0;
        end else begin
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_d  <= r_echo_s2;
        end
    end

    assign w_echo_rise    = r_echo_s2 & ~r_echo_d;
    assign w_settle_end   = (r_cnt == c_SETTLE_LAST);
    assign w_trig_end     = (r_cnt == c_TRIG_LAST);
    assign w_wait_timeout = (r_cnt == c_TIMEOUT_LAST);
    assign w_meas_timeout = (r_cnt >= c_TIMEOUT);

    // Whole cm plus half-up rounding on the leftover clocks
    assign w_cm_round  = r_cm + ((r_sub >= c_CPC_HALF) ? 32'd1 : 32'd0);
    assign w_dist_meas = (w_cm_round > 32'd999) ? c_DIST_SAT : w_cm_round[9:0];

    assign w_dist_h = 4'(r_dist / 10'd100);
    assign w_dist_t = 4'((r_dist / 10'd10) % 10'd10);
    assign w_dist_u = 4'(r_dist % 10'd10);
    assign w_angle  = angle_bcd(r_pos);

    always_comb begin
        w_char = c_ASCII_HASH;
        case (r_char_idx)
            3'd0:    w_char = c_ASCII_ZERO + {4'h0, w_angle[11:8]};
            3'd1:    w_char = c_ASCII_ZERO + {4'h0, w_angle[7:4]};
            3'd2:    w_char = c_ASCII_ZERO + {4'h0, w_angle[3:0]};
            3'd3:    w_char = c_ASCII_COMMA;
            3'd4:    w_char = c_ASCII_ZERO + {4'h0, w_dist_h};
            3'd5:    w_char = c_ASCII_ZERO + {4'h0, w_dist_t};
            3'd6:    w_char = c_ASCII_ZERO + {4'h0, w_dist_u};
            default: w_char = c_ASCII_HASH;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (ligar) w_state_next = ST_SETTLE;
            ST_SETTLE:    if (w_settle_end) w_state_next = ST_TRIG;
            ST_TRIG:      if (w_trig_end) w_state_next = ST_WAIT_ECHO;
            ST_WAIT_ECHO: begin
                if (w_echo_rise)         w_state_next = ST_MEASURE;
                else if (w_wait_timeout) w_state_next = ST_TX;
            end
            ST_MEASURE:   if (!r_echo_s2 || w_meas_timeout) w_state_next = ST_TX;
            ST_TX:        if (w_uart_done && r_char_idx == 3'd7) w_state_next = ST_DONE;
            ST_DONE:      w_state_next = ligar ? ST_SETTLE : ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    assign trigger      = (r_state == ST_TRIG);
    assign fim_posicao  = (r_state == ST_DONE);
    assign w_uart_start = (r_state == ST_TX) && r_tx_go && !w_uart_busy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 32'd0;
            r_sub      <= 32'd0;
            r_cm       <= 32'd0;
            r_dist     <= 10'd0;
            r_pos      <= 3'd0;
            r_dir_up   <= 1'b1;
            r_char_idx <= 3'd0;
            r_tx_go    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE:   r_cnt <= 32'd0;
                ST_SETTLE: r_cnt <= w_settle_end ? 32'd0 : r_cnt + 32'd1;
                ST_TRIG:   r_cnt <= w_trig_end ? 32'd0 : r_cnt + 32'd1;
                ST_WAIT_ECHO: begin
                    if (w_echo_rise) begin
                        // the rising-edge clock is the first counted echo clock
                        r_cnt <= 32'd1;
                        r_sub <= 32'd1;
                        r_cm  <= 32'd0;
                    end else if (w_wait_timeout) begin
                        r_dist     <= c_DIST_SAT;
                        r_char_idx <= 3'd0;
                        r_tx_go    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_MEASURE: begin
                    if (!r_echo_s2) begin
                        r_dist     <= w_dist_meas;
                        r_char_idx <= 3'd0;
                        r_tx_go    <= 1'b1;
                    end else if (w_meas_timeout) begin
                        r_dist     <= c_DIST_SAT;
                        r_char_idx <= 3'd0;
                        r_tx_go    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                        if (r_sub == c_CPC_LAST) begin
                            r_sub <= 32'd0;
                            r_cm  <= r_cm + 32'd1;
                        end else begin
                            r_sub <= r_sub + 32'd1;
                        end
                    end
                end
                ST_TX: begin
                    if (w_uart_start) r_tx_go <= 1'b0;
                    if (w_uart_done && r_char_idx != 3'd7) begin
                        r_char_idx <= r_char_idx + 3'd1;
                        r_tx_go    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_cnt <= 32'd0;
                    // ping-pong sweep, reversing at either end
                    if (r_dir_up) begin
                        if (r_pos == 3'd7) begin
                            r_pos    <= 3'd6;
                            r_dir_up <= 1'b0;
                        end else begin
                            r_pos <= r_pos + 3'd1;
                        end
                    end else begin
                        if (r_pos == 3'd0) begin
                            r_pos    <= 3'd1;
                            r_dir_up <= 1'b1;
                        end else begin
                            r_pos <= r_pos - 3'd1;
                        end
                    end
                end
                default: r_cnt <= 32'd0;
            endcase
        end
    end

    // New pulse width is latched only at the frame boundary
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pwm_cnt   <= 32'd0;
            r_pwm_width <= c_PWM_MIN;
        end else if (r_pwm_cnt == c_PWM_LAST) begin
            r_pwm_cnt   <= 32'd0;
            r_pwm_width <= c_PWM_MIN + c_PWM_STEP * {29'd0, r_pos};
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 32'd1;
        end
    end

    assign pwm = (r_pwm_cnt < r_pwm_width);

    sonar_uart_tx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart_tx (
        .clk     (clock),
        .rst_n   (reset),
        .i_start (w_uart_start),
        .i_data  (w_char),
        .o_tx    (w_uart_tx),
        .o_busy  (w_uart_busy),
        .o_done  (w_uart_done)
    );

    assign saida_serial         = w_uart_tx;
    assign db_echo              = r_echo_s2;
    assign db_trigger           = trigger;
    assign db_pwm               = pwm;
    assign db_saida_serial_uart = w_uart_tx;

endmodule
`default_nettype wire

// File: tb/tb_sonar.sv
`default_nettype none
// ============================================================
// Module : tb_sonar
// Brief  : directed bench for sonar with scaled-down timing parameters
// Rev    : 1.0
// ============================================================
module tb_sonar;

    localparam int P_CLK_HZ   = 1000;
    localparam int P_BAUD     = 125;   // 8 clocks per bit
    localparam int P_TRIG     = 5;
    localparam int P_CPC      = 10;
    localparam int P_SETTLE   = 20;
    localparam int P_TIMEOUT  = 1500;
    localparam int P_PWM_PER  = 400;
    localparam int P_PWM_MIN  = 50;
    localparam int P_PWM_STEP = 20;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ligar = 1'b0;
    logic echo  = 1'b0;
    logic trigger, pwm, saida_serial, fim_posicao;
    logic db_echo, db_trigger, db_pwm, db_saida_serial_uart;

    int checks = 0;
    int errors = 0;

    sonar #(
        .CLK_HZ        (P_CLK_HZ),
        .BAUD          (P_BAUD),
        .TRIG_CYCLES   (P_TRIG),
        .CYC_PER_CM    (P_CPC),
        .SETTLE_CYCLES (P_SETTLE),
        .ECHO_TIMEOUT  (P_TIMEOUT),
        .PWM_PERIOD    (P_PWM_PER),
        .PWM_MIN       (P_PWM_MIN),
        .PWM_STEP      (P_PWM_STEP)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .ligar                (ligar),
        .echo                 (echo),
        .trigger              (trigger),
        .pwm                  (pwm),
        .saida_serial         (saida_serial),
        .fim_posicao          (fim_posicao),
        .db_echo              (db_echo),
        .db_trigger           (db_trigger),
        .db_pwm               (db_pwm),
        .db_saida_serial_uart (db_saida_serial_uart)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_byte(input int bound, output logic [7:0] b, output bit ok);
        int n;
        n  = 0;
        b  = 8'h00;
        ok = 1'b0;
        while (saida_serial !== 1'b0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        if (saida_serial === 1'b0) begin
            repeat (4) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
                repeat (8) @(negedge clock);
                b[i] = saida_serial;
            end
            repeat (8) @(negedge clock);
            ok = (saida_serial === 1'b1);
        end
    endtask

    task automatic wait_trigger(output int width, input bit early);
        int n;
        n = 0;
        while (trigger !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("trigger_seen", 64'(trigger), 64'd1);
        width = 0;
        while (trigger === 1'b1 && width < 100) begin
            if (early && width == 0) echo = 1'b1;
            @(negedge clock);
            width++;
            if (early && width == 2) echo = 1'b0;
        end
    endtask

    task automatic run_position(input int echo_clks, input bit early, input bit stop_after,
                                input logic [63:0] exp_rec);
        int w;
        int n;
        logic [63:0] rec;
        logic [7:0] b;
        bit ok;
        bit all_ok;
        wait_trigger(w, early);
        check("trigger_width", 64'(w), 64'(P_TRIG));
        if (echo_clks > 0) begin
            repeat (3) @(negedge clock);
            echo = 1'b1;
            repeat (echo_clks) @(negedge clock);
            echo = 1'b0;
        end
        all_ok = 1'b1;
        rec    = 64'd0;
        for (int k = 0; k < 8; k++) begin
            rx_byte((k == 0) ? 4000 : 40, b, ok);
            all_ok = all_ok & ok;
            rec    = {rec[55:0], b};
        end
        check("uart_framing", 64'(all_ok), 64'd1);
        check("record", rec, exp_rec);
        n = 0;
        while (fim_posicao !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("fim_seen", 64'(fim_posicao), 64'd1);
        if (stop_after) ligar = 1'b0;
        @(negedge clock);
        check("fim_one_clock", 64'(fim_posicao), 64'd0);
    endtask

    task automatic pwm_count_high(output int w);
        w = 0;
        while (pwm === 1'b1 && w < 1000) begin
            @(negedge clock);
            w++;
        end
    endtask

    task automatic pwm_frame(output int w);
        int n;
        n = 0;
        while (pwm !== 1'b0 && n < 1000) begin @(negedge clock); n++; end
        n = 0;
        while (pwm !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
        pwm_count_high(w);
    endtask

    initial begin
        int w;
        int hits;
        int n;

        repeat (4) @(negedge clock);
        check("reset_trigger", 64'(trigger), 64'd0);
        check("reset_saida", 64'(saida_serial), 64'd1);
        check("reset_fim", 64'(fim_posicao), 64'd0);
        check("reset_pwm", 64'(pwm), 64'd1);
        check("reset_db_saida", 64'(db_saida_serial_uart), 64'd1);
        check("reset_db_trigger", 64'(db_trigger), 64'd0);
        reset = 1'b1;
        pwm_count_high(w);
        check("pwm_pos0_high", 64'(w), 64'd50);
        ligar = 1'b1;

        run_position(1000, 1'b0, 1'b0, "020,100#");
        run_position(1003, 1'b0, 1'b0, "040,100#");
        run_position(740,  1'b0, 1'b0, "060,074#");
        run_position(745,  1'b0, 1'b0, "080,075#");
        run_position(100,  1'b0, 1'b0, "100,010#");
        run_position(170,  1'b0, 1'b0, "120,017#");
        run_position(74,   1'b0, 1'b0, "140,007#");
        run_position(500,  1'b1, 1'b0, "160,050#");
        run_position(300,  1'b0, 1'b0, "140,030#");
        run_position(220,  1'b0, 1'b1, "120,022#");

        hits = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (trigger === 1'b1) hits++;
        end
        check("idle_no_trigger", 64'(hits), 64'd0);
        pwm_frame(w);
        check("pwm_pos4_high", 64'(w), 64'd130);
        ligar = 1'b1;
        run_position(250, 1'b0, 1'b0, "100,025#");
        run_position(0,   1'b0, 1'b0, "080,999#");

        wait_trigger(w, 1'b0);
        check("pos2_trigger_width", 64'(w), 64'(P_TRIG));
        repeat (3) @(negedge clock);
        echo = 1'b1;
        repeat (200) @(negedge clock);
        echo = 1'b0;
        n = 0;
        while (saida_serial !== 1'b0 && n < 500) begin @(negedge clock); n++; end
        check("tx_started", 64'(saida_serial), 64'd0);
        repeat (20) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midtx_saida", 64'(saida_serial), 64'd1);
        check("midtx_trigger", 64'(trigger), 64'd0);
        check("midtx_fim", 64'(fim_posicao), 64'd0);
        ligar = 1'b0;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (fim_posicao === 1'b1 || saida_serial !== 1'b1) hits++;
        end
        check("reset_hold_quiet", 64'(hits), 64'd0);
        reset = 1'b1;
        pwm_count_high(w);
        check("pwm_after_reset", 64'(w), 64'd50);
        check("no_trigger_ligar0", 64'(trigger), 64'd0);
        ligar = 1'b1;
        run_position(400, 1'b0, 1'b0, "020,040#");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
